iq_avg_ctrl: RTL and testbench
==============================

# iq_avg_ctrl

Window controller for the I/Q averaging path. Frames the incoming I/Q sample stream into fixed windows of 2^ABITS samples and sequences two accumulator lanes, one for I and one for Q. At each window end it transfers the scaled sums into a valid/ready output register. When the consumer stalls, it detects and counts dropped windows. It sits between the demodulator I/Q stream and the PS-side capture logic.

## Interface
- NBITS, 32, width of signed I/Q samples and averages
- ABITS, 8, log2 of window length; window = 2^ABITS samples, average = sum >>> ABITS
- CNTW, 16, width of window_count and drop_count

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  run averaging; 0 aborts the current window
- s_valid  in  1  sample strobe; no backpressure, always accepted when counted
- s_i  in  NBITS  signed I sample
- s_q  in  NBITS  signed Q sample
- m_valid  out  1  average pair available
- m_ready  in  1  consumer accepts pair when m_valid&&m_ready
- m_i  out  NBITS  signed I average
- m_q  out  NBITS  signed Q average
- busy  out  1  FSM in ACCUM
- overrun  out  1  one-cycle pulse: completed window dropped
- window_count  out  CNTW  completed windows delivered to output register, wraps
- drop_count  out  CNTW  dropped windows, saturates at all-ones

## Operation
- FSM states:
  - IDLE: accumulators and sample counter held at 0. Goes to ACCUM when enable=1.
  - ACCUM: each cycle with s_valid=1 and enable=1 adds sign-extended s_i/s_q into (NBITS+ABITS)-bit accumulators and increments the ABITS-bit counter.
  - ABORT: entered from ACCUM when enable=0. The partial window is discarded: accumulators and counter are cleared. Next cycle goes to IDLE.
- Window end: the accepted sample with counter == 2^ABITS-1.
  - result = (acc + sample)[NBITS+ABITS-1:ABITS], per lane, computed combinationally that cycle.
  - Accumulators reload to 0 and the counter wraps to 0 on the same edge, so there is no dead cycle and the next sample starts a new window.
- Output register:
  - Loaded with the result if m_valid=0, or if m_valid&&m_ready in that cycle; window_count increments.
  - Otherwise the result is discarded, the old pair is kept, overrun pulses, and drop_count increments (saturating).
- m_valid clears on m_valid&&m_ready unless it is reloaded in the same cycle.
- A pending output pair survives enable=0 and stays presented until consumed.
- Sums never overflow: the accumulator has ABITS guard bits. The average is arithmetic (floor) division.

## Timing
- Reset values: m_valid=0, m_i=0, m_q=0, busy=0, overrun=0, window_count=0, drop_count=0. FSM in IDLE, accumulators and counter 0.
- enable rising edge: ACCUM the next cycle. A sample in the cycle enable rises is not counted.
- Latency: m_valid rises on the edge after the final window sample is accepted.
- enable falling edge in ACCUM: a sample in that cycle is ignored. ABORT for 1 cycle, then IDLE.
- If enable drops in the same cycle as the final sample, that sample is ignored and the window is aborted.
- rst mid-window overrides everything: all state returns to reset values on the next edge.
- overrun is high for exactly one cycle per dropped window.

## Structure
- Shared package iq_avg_pkg:
  - state enum (IDLE, ACCUM, ABORT)
  - localparam WIN = 2**ABITS
  - localparam AW = NBITS+ABITS
- Sub-module iq_acc_lane, instantiated twice (I, Q). It contains the accumulator, sign extension, clear/add controls and the scaled result output.
- The FSM, counter and output register stay in iq_avg_ctrl.

## Test plan
- ABITS=2, enable=1, I=1,2,3,4 and Q=-1,-2,-3,-4 on consecutive s_valid, m_ready=1 -> one cycle after the 4th sample: m_i=2, m_q=-3, m_valid=1 for 1 cycle, window_count=1.
- Gapped s_valid (1 of every 3 cycles), I=Q=8 for 8 samples -> two pairs of 8/8, each one cycle after its 4th valid sample.
- m_ready=0 for 3 windows of I=5,6,7 (constant per window) -> m_i holds 5, overrun pulses twice, drop_count=2; m_ready=1 -> pair 5 consumed.
- Final sample coincides with m_valid&&m_ready -> new pair loaded, m_valid stays 1, no overrun.
- enable dropped after 2 of 4 samples, re-raised, then I=4×100 -> average 100, no contamination from the partial window.
- rst asserted mid-window with m_valid=1 -> all outputs 0 next cycle; the next full window gives the correct average.

Source files
------------

// File: rtl/iq_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iq_avg_pkg
// Purpose  : Shared types and default sizing for the I/Q window averager.
//            Holds the controller state encoding and the default widths used
//            by iq_avg_ctrl and iq_acc_lane.
// Revision : 1.0 - initial release
// ============================================================================
package iq_avg_pkg;

  // Default configuration; the modules re-derive their own widths from their
  // parameters, these are only the power-on defaults.
  localparam int DEF_NBITS = 32;
  localparam int DEF_ABITS = 8;
  localparam int DEF_CNTW  = 16;

  // Window length and accumulator width for the default configuration.
  localparam int WIN = 2 ** DEF_ABITS;
  localparam int AW  = DEF_NBITS + DEF_ABITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ABORT = 2'd2
  } state_t;

endpackage : iq_avg_pkg
`default_nettype wire

// File: rtl/iq_acc_lane.sv
`default_nettype none
// ============================================================================
// Module   : iq_acc_lane
// Purpose  : One accumulator lane (I or Q) of the window averager.
//            Sign-extends each sample into an (NBITS+ABITS)-bit accumulator
//            and presents the scaled window result combinationally.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            clr             - clear accumulator on this edge (wins over add)
//            add             - accumulate sample on this edge
//            sample [NBITS]  - signed input sample
//            result [NBITS]  - (acc + sample) >>> ABITS, valid in the cycle
//                              of the final window sample
// Revision : 1.0 - initial release
// ============================================================================
module iq_acc_lane
  import iq_avg_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int ABITS = DEF_ABITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    add,
  input  logic signed [NBITS-1:0] sample,
  output logic signed [NBITS-1:0] result
);

  localparam int ACC_W = NBITS + ABITS;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;

  assign sample_ext = {{ABITS{sample[NBITS-1]}}, sample};
  assign sum        = acc + sample_ext;

  // Dropping the low ABITS bits of a two's-complement sum is a floor divide.
  assign result = sum[ACC_W-1:ABITS];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= sum;
    end
  end

endmodule : iq_acc_lane
`default_nettype wire

// File: rtl/iq_avg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iq_avg_ctrl
// Purpose  : Window controller for the I/Q averaging path. Frames the sample
//            stream into 2^ABITS-sample windows, sequences the two
//            accumulator lanes and hands averages to a valid/ready register,
//            counting delivered and dropped windows.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            enable                - run averaging; low aborts current window
//            s_valid, s_i, s_q     - sample strobe and signed I/Q samples
//            m_valid, m_ready      - output handshake
//            m_i, m_q              - signed I/Q averages
//            busy                  - controller accumulating
//            overrun               - one-cycle pulse per dropped window
//            window_count          - delivered windows (wraps)
//            drop_count            - dropped windows (saturates)
// Revision : 1.0 - initial release
// ============================================================================
module iq_avg_ctrl
  import iq_avg_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int ABITS = DEF_ABITS,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    s_valid,
  input  logic signed [NBITS-1:0] s_i,
  input  logic signed [NBITS-1:0] s_q,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [NBITS-1:0] m_i,
  output logic signed [NBITS-1:0] m_q,
  output logic                    busy,
  output logic                    overrun,
  output logic [CNTW-1:0]         window_count,
  output logic [CNTW-1:0]         drop_count
);

  state_t                  state;
  state_t                  state_nx;
  logic [ABITS-1:0]        cnt;
  logic                    accept;
  logic                    win_end;
  logic                    lane_clr;
  logic                    load_ok;
  logic signed [NBITS-1:0] res_i;
  logic signed [NBITS-1:0] res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    accept   = 1'b0;
    win_end  = 1'b0;
    lane_clr = 1'b1;
    case (state)
      IDLE: begin
        if (enable) state_nx = ACCUM;
      end
      ACCUM: begin
        busy     = 1'b1;
        lane_clr = 1'b0;
        if (!enable) begin
          state_nx = ABORT;
        end else if (s_valid) begin
          accept  = 1'b1;
          win_end = (cnt == '1);
          // Reload on the final sample so the next sample opens a new window.
          lane_clr = win_end;
        end
      end
      ABORT: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || lane_clr) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + ABITS'(1);
    end
  end

  iq_acc_lane #(
    .NBITS (NBITS),
    .ABITS (ABITS)
  ) u_lane_i (
    .clk    (clk),
    .rst    (rst),
    .clr    (lane_clr),
    .add    (accept),
    .sample (s_i),
    .result (res_i)
  );

  iq_acc_lane #(
    .NBITS (NBITS),
    .ABITS (ABITS)
  ) u_lane_q (
    .clk    (clk),
    .rst    (rst),
    .clr    (lane_clr),
    .add    (accept),
    .sample (s_q),
    .result (res_q)
  );

  // The register may take a new pair if it is empty or being drained now.
  assign load_ok = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid      <= 1'b0;
      m_i          <= '0;
      m_q          <= '0;
      overrun      <= 1'b0;
      window_count <= '0;
      drop_count   <= '0;
    end else begin
      overrun <= 1'b0;
      if (win_end && load_ok) begin
        m_valid      <= 1'b1;
        m_i          <= res_i;
        m_q          <= res_q;
        window_count <= window_count + CNTW'(1);
      end else begin
        if (m_valid && m_ready) m_valid <= 1'b0;
        if (win_end) begin
          overrun <= 1'b1;
          if (drop_count != '1) drop_count <= drop_count + CNTW'(1);
        end
      end
    end
  end

endmodule : iq_avg_ctrl
`default_nettype wire

// File: tb/tb_iq_avg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_avg_ctrl
// Purpose  : Self-checking bench for iq_avg_ctrl (ABITS=2, CNTW=4). A
//            window-level reference model queues expected average pairs; a
//            monitor compares them and the status outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iq_avg_ctrl;

  localparam int NBITS = 32;
  localparam int ABITS = 2;
  localparam int CNTW  = 4;
  localparam int W     = 4;
  localparam int CMAX  = 15;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic                    s_valid;
  logic signed [NBITS-1:0] s_i;
  logic signed [NBITS-1:0] s_q;
  logic                    m_valid;
  logic                    m_ready;
  logic signed [NBITS-1:0] m_i;
  logic signed [NBITS-1:0] m_q;
  logic                    busy;
  logic                    overrun;
  logic [CNTW-1:0]         window_count;
  logic [CNTW-1:0]         drop_count;

  always #5 clk = ~clk;

  iq_avg_ctrl #(
    .NBITS (NBITS),
    .ABITS (ABITS),
    .CNTW  (CNTW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .s_valid      (s_valid),
    .s_i          (s_i),
    .s_q          (s_q),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_i          (m_i),
    .m_q          (m_q),
    .busy         (busy),
    .overrun      (overrun),
    .window_count (window_count),
    .drop_count   (drop_count)
  );

  typedef struct {
    longint i;
    longint q;
  } pair_t;

  int     vectors     = 0;
  int     miscompares = 0;
  pair_t  exp_q[$];
  longint win_i[$];
  longint win_q[$];
  bit     running  = 0;   // model: window collection active
  bit     aborting = 0;   // model: one cycle of abort pending
  bit     pend     = 0;   // model: a pair is presented
  bit     exp_ovr  = 0;
  bit     was_rst  = 0;
  bit     started  = 0;
  int     exp_wc   = 0;
  int     exp_dc   = 0;

  function automatic longint floor_avg(input longint s);
    longint r;
    r = s / W;
    if ((s % W) != 0 && s < 0) r = r - 1;
    return r;
  endfunction

  // Applied at each active edge with the inputs that edge sees.
  task automatic model_step();
    longint si;
    longint sq;
    pair_t  p;
    exp_ovr = 0;
    was_rst = 0;
    started = 1;
    if (rst) begin
      running = 0; aborting = 0; pend = 0;
      exp_wc = 0; exp_dc = 0; was_rst = 1;
      win_i.delete(); win_q.delete(); exp_q.delete();
      return;
    end
    if (pend && m_ready) pend = 0;
    if (aborting) begin
      aborting = 0;
    end else if (!running) begin
      if (enable) running = 1;
    end else if (!enable) begin
      running = 0; aborting = 1;
      win_i.delete(); win_q.delete();
    end else if (s_valid) begin
      win_i.push_back(longint'(s_i));
      win_q.push_back(longint'(s_q));
      if (win_i.size() == W) begin
        si = 0; sq = 0;
        foreach (win_i[k]) begin si += win_i[k]; sq += win_q[k]; end
        win_i.delete(); win_q.delete();
        if (!pend) begin
          p.i = floor_avg(si);
          p.q = floor_avg(sq);
          exp_q.push_back(p);
          pend = 1;
          exp_wc = (exp_wc + 1) % (CMAX + 1);
        end else begin
          exp_ovr = 1;
          if (exp_dc < CMAX) exp_dc = exp_dc + 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: compare outputs away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("m_valid", longint'(m_valid), longint'(pend));
        chk("busy", longint'(busy), longint'(running));
        chk("overrun", longint'(overrun), longint'(exp_ovr));
        chk("window_count", longint'(window_count), longint'(exp_wc));
        chk("drop_count", longint'(drop_count), longint'(exp_dc));
        if (was_rst) begin
          chk("rst_m_i", longint'(m_i), 0);
          chk("rst_m_q", longint'(m_q), 0);
        end
        if (m_valid) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pair_present at %0t: m_i=%0d m_q=%0d but none expected",
                     $time, m_i, m_q);
          end else begin
            chk("m_i", longint'(m_i), exp_q[0].i);
            chk("m_q", longint'(m_q), exp_q[0].q);
            if (m_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic cycle(input bit r, input bit e, input bit v,
                       input int i, input int q, input bit rdy);
    rst = r; enable = e; s_valid = v; s_i = i; s_q = q; m_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cycle(0, 1, 0, 0, 0, rdy);
  endtask

  task automatic window(input int vi, input int vq, input bit rdy);
    for (int k = 0; k < W; k++) cycle(0, 1, 1, vi, vq, rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1; enable = 0; s_valid = 0; s_i = 0; s_q = 0; m_ready = 0;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);

    // Basic window; the sample on the enable-rise cycle is not counted.
    cycle(0, 1, 1, 99, 99, 1);
    for (int k = 1; k <= 4; k++) cycle(0, 1, 1, k, -k, 1);
    idle(2, 1);

    // Gapped strobe, two windows of 8.
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, 1, 8, 8, 1);
      idle(2, 1);
    end

    // Stalled consumer: first window held, next two dropped.
    window(5, 5, 0);
    window(6, 6, 0);
    window(7, 7, 0);
    idle(3, 1);

    // Final sample coincides with a handshake.
    window(10, -10, 0);
    for (int k = 0; k < 3; k++) cycle(0, 1, 1, 20, -20, 0);
    cycle(0, 1, 1, 20, -20, 1);
    idle(2, 1);

    // Abort after two samples, then a clean window of 100.
    cycle(0, 1, 1, 50, 50, 1);
    cycle(0, 1, 1, 50, 50, 1);
    cycle(0, 0, 1, 50, 50, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 1, 77, 77, 1);
    window(100, 100, 1);
    idle(2, 1);

    // Reset mid-window with a pair pending.
    window(7, 7, 0);
    cycle(0, 1, 1, 9, 9, 0);
    cycle(0, 1, 1, 9, 9, 0);
    cycle(1, 1, 1, 9, 9, 0);
    cycle(0, 1, 0, 0, 0, 1);
    window(-13, -11, 1);
    idle(2, 1);

    // Long stall: drop_count saturates, window_count wraps later.
    for (int w = 0; w < 18; w++) window($urandom, $urandom, 0);
    idle(3, 1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) != 0),
            $urandom_range(0, 1), $urandom, $urandom,
            (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end
    idle(4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_iq_avg_ctrl
`default_nettype wire
